deflect_port_alloc: RTL and testbench
=====================================

Name: deflect_port_alloc

Overview:
- Deflection port allocator for the bufferless router, one pipeline stage.
- Sits directly downstream of route computation and consumes one 5-bit productive-port vector per flit.
- Assigns up to four network flits plus one local injection to the five output ports by oldest-first priority, ejecting or deflecting as needed.
- Results are registered toward the link drivers.

Parameters:
- AGE_W, 8, width of the flit age field (hop count).
- DATA_W, 32, width of the opaque flit payload (destination, source, data).
- CNT_W, 16, width of the deflection statistics counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  4  flit present on network input i (0-W, 1-E, 2-S, 3-N).
- in_age  input  4*AGE_W  age of input i, slice [i*AGE_W +: AGE_W].
- in_prod  input  4*5  productive vector of input i, slice [i*5 +: 5]; bit order 4-LOCAL, 3-N, 2-S, 1-E, 0-W.
- in_data  input  4*DATA_W  payload of input i.
- inj_valid  input  1  local core requests injection.
- inj_prod  input  5  productive vector of the injected flit; bit 4 ignored.
- inj_data  input  DATA_W  injected payload.
- inj_ack  output  1  combinational; injection accepted this cycle.
- out_valid  output  5  registered; flit leaving on port p.
- out_age  output  5*AGE_W  registered; age of flit on port p.
- out_data  output  5*DATA_W  registered; payload on port p.
- defl_cnt  output  CNT_W  registered; saturating count of deflected flits.

Behaviour:
- Reset (async, active-high): out_valid=0, out_age=0, out_data=0, defl_cnt=0. Asserting reset mid-operation discards every in-flight allocation. First registered output appears one cycle after reset deasserts.
- No backpressure. A valid network input is always assigned exactly one output port in the same cycle, and appears on out_* at the next rising edge (latency 1).
- Priority order:
  - Valid network inputs sorted by age, largest first.
  - Equal ages: lower input index wins.
  - Injection is always lowest priority.
- Greedy allocation, evaluated in priority order each cycle:
  - Flit takes the lowest-index free port p with in_prod[p]=1. Port 4 is eligible only via prod bit 4.
  - If no productive port is free, the flit is deflected to the lowest-index free network port (0..3). It never deflects to port 4.
  - Four network ports with at most four network flits guarantees a deflection target always exists.
- Ejection: at most one flit per cycle on port 4, namely the highest-priority flit with prod[4]=1. Other ejecting flits deflect.
- Injection:
  - inj_ack=1 iff inj_valid=1 and at least one network port remains free after all network flits are allocated.
  - Injected flit takes the lowest-index free productive network port, else the lowest-index free network port.
  - A non-productive placement of an injected flit is not counted as a deflection.
  - inj_ack=0 leaves the injector holding its flit; nothing is latched.
- Age arithmetic:
  - out_age = in_age+1, saturating at 2^AGE_W-1.
  - Injected flit leaves with age 1.
  - Ejected flit on port 4 carries its incremented age.
- Unassigned ports register out_valid=0, out_data=0, out_age=0.
- defl_cnt adds the number of deflected network flits (0..4) each cycle, saturating at 2^CNT_W-1. It never wraps.
- in_prod of an invalid input is ignored. An all-zero in_prod on a valid input is treated as fully deflected and counted.

Test Plan:
1. Reset mid-traffic: reset=1 with all inputs valid -> out_valid=00000 and defl_cnt=0 immediately. Next edge after release registers the new allocation.
2. Single flit: W valid, age 3, prod=00010 -> next cycle out_valid=00010, out_age[1]=4, data preserved, defl_cnt unchanged.
3. Conflict: W age 5 prod=01000, E age 9 prod=01000 -> E on port 3 (age 10); W deflected to port 0 (age 6); defl_cnt+=1.
4. Age tie on ejection: S and N both age 7, prod=10000 -> S (index 2) on port 4; N deflected to port 0; defl_cnt+=1.
5. Injection: three network flits take ports 3, 2, 1; inj_valid=1, inj_prod=00001 -> inj_ack=1, port 0 carries inj_data with age 1. With four network flits valid -> inj_ack=0.
6. Saturation: in_age=255 (AGE_W=8) -> out_age=255. defl_cnt preloaded near 2^16-1 by sustained 4-deflection traffic -> holds at 65535.

Source files
------------

// File: rtl/deflect_port_alloc.sv
// Deflection port allocator: oldest-first greedy assignment of four network flits
// plus one local injection onto five output ports, with registered outputs.
module deflect_port_alloc #(
  parameter int AGE_W  = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          in_valid,
  input  logic [4*AGE_W-1:0]  in_age,
  input  logic [4*5-1:0]      in_prod,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic                inj_valid,
  input  logic [4:0]          inj_prod,
  input  logic [DATA_W-1:0]   inj_data,
  output logic                inj_ack,
  output logic [4:0]          out_valid,
  output logic [5*AGE_W-1:0]  out_age,
  output logic [5*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]    defl_cnt
);

  logic [AGE_W-1:0]  ageIn   [4];
  logic [AGE_W-1:0]  ageNext [4];
  logic [4:0]        prodIn  [4];
  logic [DATA_W-1:0] dataIn  [4];
  logic [2:0]        rank    [4];

  logic [4:0]        busy;
  logic [1:0]        portIdx [5];
  logic [4:0]        portInj;
  logic [2:0]        deflCount;
  logic              placed;
  logic              injAck;

  logic [4:0]         nextValid;
  logic [5*AGE_W-1:0] nextAge;
  logic [5*DATA_W-1:0] nextData;
  logic [CNT_W:0]     cntSum;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      ageIn[i]   = in_age[i*AGE_W +: AGE_W];
      prodIn[i]  = in_prod[i*5 +: 5];
      dataIn[i]  = in_data[i*DATA_W +: DATA_W];
      ageNext[i] = (ageIn[i] == '1) ? ageIn[i] : ageIn[i] + 1'b1;
    end
  end

  // Rank = number of valid inputs that beat this one (older, or equal age with lower index).
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      rank[i] = '0;
      for (int unsigned j = 0; j < 4; j++) begin
        if (j != i && in_valid[j] &&
            (ageIn[j] > ageIn[i] || (ageIn[j] == ageIn[i] && j < i)))
          rank[i] = rank[i] + 3'd1;
      end
    end
  end

  always_comb begin
    busy      = '0;
    portInj   = '0;
    deflCount = '0;
    placed    = 1'b0;
    injAck    = 1'b0;
    for (int unsigned p = 0; p < 5; p++) portIdx[p] = '0;

    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (in_valid[i] && rank[i] == 3'(r)) begin
          placed = 1'b0;
          for (int unsigned p = 0; p < 5; p++) begin
            if (!placed && prodIn[i][p] && !busy[p]) begin
              busy[p]    = 1'b1;
              portIdx[p] = 2'(i);
              placed     = 1'b1;
            end
          end
          if (!placed) begin
            deflCount = deflCount + 3'd1;
            for (int unsigned p = 0; p < 4; p++) begin
              if (!placed && !busy[p]) begin
                busy[p]    = 1'b1;
                portIdx[p] = 2'(i);
                placed     = 1'b1;
              end
            end
          end
        end
      end
    end

    if (inj_valid && busy[3:0] != 4'hF) begin
      injAck = 1'b1;
      placed = 1'b0;
      for (int unsigned p = 0; p < 4; p++) begin
        if (!placed && inj_prod[p] && !busy[p]) begin
          busy[p] = 1'b1; portInj[p] = 1'b1; placed = 1'b1;
        end
      end
      for (int unsigned p = 0; p < 4; p++) begin
        if (!placed && !busy[p]) begin
          busy[p] = 1'b1; portInj[p] = 1'b1; placed = 1'b1;
        end
      end
    end
  end

  assign inj_ack = injAck;

  always_comb begin
    nextValid = busy;
    nextAge   = '0;
    nextData  = '0;
    for (int unsigned p = 0; p < 5; p++) begin
      if (portInj[p]) begin
        nextAge[p*AGE_W +: AGE_W]    = AGE_W'(1);
        nextData[p*DATA_W +: DATA_W] = inj_data;
      end else if (busy[p]) begin
        nextAge[p*AGE_W +: AGE_W]    = ageNext[portIdx[p]];
        nextData[p*DATA_W +: DATA_W] = dataIn[portIdx[p]];
      end
    end
  end

  assign cntSum = {1'b0, defl_cnt} + {{(CNT_W-2){1'b0}}, deflCount};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= '0;
      out_age   <= '0;
      out_data  <= '0;
      defl_cnt  <= '0;
    end else begin
      out_valid <= nextValid;
      out_age   <= nextAge;
      out_data  <= nextData;
      defl_cnt  <= cntSum[CNT_W] ? '1 : cntSum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_deflect_port_alloc.sv
// Directed table-driven bench for deflect_port_alloc plus reset and saturation sequences.
module tb_deflect_port_alloc;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_valid;
    logic [31:0]  in_age;
    logic [19:0]  in_prod;
    logic [127:0] in_data;
    logic         inj_valid;
    logic [4:0]   inj_prod;
    logic [31:0]  inj_data;
    logic         inj_ack;
    logic [4:0]   out_valid;
    logic [39:0]  out_age;
    logic [159:0] out_data;
    logic [15:0]  defl_cnt;

    int checks = 0;
    int errors = 0;

    deflect_port_alloc #(.AGE_W(8), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_age(in_age), .in_prod(in_prod), .in_data(in_data),
        .inj_valid(inj_valid), .inj_prod(inj_prod), .inj_data(inj_data), .inj_ack(inj_ack),
        .out_valid(out_valid), .out_age(out_age), .out_data(out_data), .defl_cnt(defl_cnt)
    );

    always #5 clk = ~clk;

    // Ages/prods packed {N,S,E,W}; expected src/age packed {p4,p3,p2,p1,p0}; src 4 = injection, 7 = unused.
    typedef struct {
        logic [3:0]  v;
        logic [31:0] age;
        logic [19:0] prod;
        logic        injV;
        logic [4:0]  injP;
        logic [4:0]  expValid;
        logic        expAck;
        logic [14:0] expSrc;
        logic [39:0] expAge;
        logic [2:0]  expDefl;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] netData(input int k, input int i);
        return 32'hC0DE_0000 | (k << 4) | i;
    endfunction

    function automatic logic [31:0] injDataFor(input int k);
        return 32'h1A1A_0000 | k;
    endfunction

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t t, input int k);
        in_valid  = t.v;
        in_age    = t.age;
        in_prod   = t.prod;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = netData(k, i);
        inj_valid = t.injV;
        inj_prod  = t.injP;
        inj_data  = injDataFor(k);
    endtask

    initial begin
        logic [159:0] expData;
        logic [2:0]   src;
        logic [15:0]  prevCnt;

        vecs[0]  = '{4'b0001, {8'd0,8'd0,8'd0,8'd3}, {5'b0,5'b0,5'b0,5'b00010}, 1'b0, 5'b0,
                     5'b00010, 1'b0, {3'd7,3'd7,3'd7,3'd0,3'd7}, {8'd0,8'd0,8'd0,8'd4,8'd0}, 3'd0};
        vecs[1]  = '{4'b0011, {8'd0,8'd0,8'd9,8'd5}, {5'b0,5'b0,5'b01000,5'b01000}, 1'b0, 5'b0,
                     5'b01001, 1'b0, {3'd7,3'd1,3'd7,3'd7,3'd0}, {8'd0,8'd10,8'd0,8'd0,8'd6}, 3'd1};
        vecs[2]  = '{4'b1100, {8'd7,8'd7,8'd0,8'd0}, {5'b10000,5'b10000,5'b0,5'b0}, 1'b0, 5'b0,
                     5'b10001, 1'b0, {3'd2,3'd7,3'd7,3'd7,3'd3}, {8'd8,8'd0,8'd0,8'd0,8'd8}, 3'd1};
        vecs[3]  = '{4'b0111, {8'd0,8'd2,8'd2,8'd2}, {5'b0,5'b00010,5'b00100,5'b01000}, 1'b1, 5'b00001,
                     5'b01111, 1'b1, {3'd7,3'd0,3'd1,3'd2,3'd4}, {8'd0,8'd3,8'd3,8'd3,8'd1}, 3'd0};
        vecs[4]  = '{4'b1111, {8'd1,8'd1,8'd1,8'd1}, {5'b01000,5'b00100,5'b00010,5'b00001}, 1'b1, 5'b00001,
                     5'b01111, 1'b0, {3'd7,3'd3,3'd2,3'd1,3'd0}, {8'd0,8'd2,8'd2,8'd2,8'd2}, 3'd0};
        vecs[5]  = '{4'b0001, {8'd0,8'd0,8'd0,8'd255}, {5'b0,5'b0,5'b0,5'b10000}, 1'b0, 5'b0,
                     5'b10000, 1'b0, {3'd0,3'd7,3'd7,3'd7,3'd7}, {8'd255,8'd0,8'd0,8'd0,8'd0}, 3'd0};
        vecs[6]  = '{4'b0010, {8'd0,8'd0,8'd4,8'd0}, 20'b0, 1'b1, 5'b00001,
                     5'b00011, 1'b1, {3'd7,3'd7,3'd7,3'd4,3'd1}, {8'd0,8'd0,8'd0,8'd1,8'd5}, 3'd1};
        vecs[7]  = '{4'b1000, {8'd0,8'd0,8'd0,8'd99}, {5'b00100,5'b0,5'b0,5'b11111}, 1'b0, 5'b0,
                     5'b00100, 1'b0, {3'd7,3'd7,3'd3,3'd7,3'd7}, {8'd0,8'd0,8'd1,8'd0,8'd0}, 3'd0};
        vecs[8]  = '{4'b1111, {8'd10,8'd7,8'd10,8'd3}, {5'b10001,5'b00001,5'b00001,5'b00001}, 1'b1, 5'b01000,
                     5'b11111, 1'b1, {3'd3,3'd4,3'd0,3'd2,3'd1}, {8'd11,8'd1,8'd4,8'd8,8'd11}, 3'd2};
        vecs[9]  = '{4'b0111, {8'd0,8'd6,8'd6,8'd2}, {5'b0,5'b10001,5'b10000,5'b10000}, 1'b0, 5'b0,
                     5'b10011, 1'b0, {3'd1,3'd7,3'd7,3'd0,3'd2}, {8'd7,8'd0,8'd0,8'd3,8'd7}, 3'd1};
        vecs[10] = '{4'b0000, 32'b0, 20'b0, 1'b1, 5'b10000,
                     5'b00001, 1'b1, {3'd7,3'd7,3'd7,3'd7,3'd4}, {8'd0,8'd0,8'd0,8'd0,8'd1}, 3'd0};

        reset = 1'b1;
        drive(vecs[4], 4);
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 160'(out_valid), 160'(0));
        check("reset out_age", 160'(out_age), 160'(0));
        check("reset out_data", out_data, 160'(0));
        check("reset defl_cnt", 160'(defl_cnt), 160'(0));
        reset = 1'b0;

        for (int k = 0; k < 11; k++) begin
            drive(vecs[k], k);
            prevCnt = defl_cnt;
            #1;
            check($sformatf("v%0d inj_ack", k), 160'(inj_ack), 160'(vecs[k].expAck));
            @(posedge clk);
            #1;
            expData = '0;
            for (int p = 0; p < 5; p++) begin
                src = vecs[k].expSrc[p*3 +: 3];
                if (src == 3'd4) expData[p*32 +: 32] = injDataFor(k);
                else if (src != 3'd7) expData[p*32 +: 32] = netData(k, int'(src));
            end
            check($sformatf("v%0d out_valid", k), 160'(out_valid), 160'(vecs[k].expValid));
            check($sformatf("v%0d out_age", k), 160'(out_age), 160'(vecs[k].expAge));
            check($sformatf("v%0d out_data", k), out_data, expData);
            check($sformatf("v%0d defl_delta", k), 160'(defl_cnt - prevCnt), 160'(vecs[k].expDefl));
        end

        // Reset asserted mid-traffic, away from the clock edge.
        drive(vecs[8], 8);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset out_valid", 160'(out_valid), 160'(0));
        check("midreset defl_cnt", 160'(defl_cnt), 160'(0));
        @(negedge clk);
        reset = 1'b0;
        drive(vecs[1], 1);
        @(posedge clk);
        #1;
        check("postreset out_valid", 160'(out_valid), 160'(5'b01001));
        check("postreset out_age", 160'(out_age), 160'({8'd0,8'd10,8'd0,8'd0,8'd6}));
        check("postreset defl_cnt", 160'(defl_cnt), 160'(1));

        // Sustained four-way deflection drives the counter into saturation.
        in_valid  = 4'b1111;
        in_age    = '0;
        in_prod   = '0;
        inj_valid = 1'b0;
        @(posedge clk);
        #1;
        check("defl4 first", 160'(defl_cnt), 160'(5));
        check("defl4 valid", 160'(out_valid), 160'(5'b01111));
        repeat (16400) @(posedge clk);
        #1;
        check("defl_cnt saturated", 160'(defl_cnt), 160'(16'hFFFF));
        @(posedge clk);
        #1;
        check("defl_cnt holds", 160'(defl_cnt), 160'(16'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
